control_juego: RTL and testbench
================================

# control_juego

Top-level game sequencer for HEROE. Runs the six-state game machine (OFF, WLCM, CH, GAME, WL, PA) from player buttons. Drives `presente` and `W_or_L` to the obstacle generator and display logic. Counts survived obstacle steps, declares win or loss, and holds the selected character.

## Interface
- `WLCM_CYCLES`, default 27_000_000: welcome-screen duration in clk cycles (1 s at 27 MHz).
- `WL_CYCLES`, default 81_000_000: win/lose screen duration in clk cycles.
- `WIN_TICKS`, default 7'd60: obstacle steps to survive for a win, range 1..127.
- `OFF`/`WLCM`/`CH`/`GAME`/`WL`/`PA`, default 3'd0..3'd5: state encodings, shared codebase-wide.
- `clk`  in  1  system clock (27 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `btn_power`  in  1  power toggle, synchronous, debounced level.
- `btn_start`  in  1  start/confirm, synchronous, debounced level.
- `btn_pause`  in  1  pause toggle, synchronous, debounced level.
- `btn_sel`  in  1  character select, synchronous, debounced level.
- `tick_obs`  in  1  one-clk pulse per obstacle scroll step.
- `colision`  in  1  level: hero overlaps an obstacle in the current step.
- `presente`  out  3  current state, registered.
- `W_or_L`  out  2  00 = playing/none, 01 = lose, 10 = win; 11 is never driven.
- `personaje`  out  2  selected character index.
- `score`  out  7  obstacle steps survived in the current/last game.

## Operation
- Button edges: `X_e = btn_X & ~btn_X_q`. `btn_X_q` is a registered copy of the button, reset 0. Only rising edges act; held buttons do nothing further.
- `timer`: a 27-bit counter. It is cleared on every state change and increments in WLCM and WL only.
- Power priority: `btn_power_e` in any state other than OFF goes to OFF. It also clears `W_or_L`, `score` and `timer`, and keeps `personaje`. This overrides every other event in the same cycle.
- OFF: `btn_power_e` goes to WLCM. All other inputs are ignored.
- WLCM:
  - `btn_start_e` goes to CH.
  - Otherwise, when `timer == WLCM_CYCLES-1`, go to CH.
- CH:
  - `btn_sel_e` sets `personaje <= personaje + 1`, wrapping 3→0.
  - `btn_start_e` goes to GAME and sets `score <= 0`, `W_or_L <= 00`.
  - If both edges occur in the same cycle, start wins and `personaje` is not incremented.
- GAME, evaluated in this priority order:
  1. `btn_pause_e` goes to PA. A tick or collision in that same cycle is ignored.
  2. `tick_obs && colision` sets `W_or_L <= 01` and goes to WL. `score` is not incremented.
  3. `tick_obs` sets `score <= score + 1`. If `score + 1 == WIN_TICKS`, also set `W_or_L <= 10` and go to WL.
  4. `colision` without `tick_obs` has no effect. Collision is judged only at step boundaries.
- PA:
  - `btn_pause_e` returns to GAME.
  - `tick_obs` and `colision` are ignored.
  - `score`, `personaje` and `W_or_L` are held.
- WL:
  - `W_or_L` and `score` are held.
  - `btn_start_e` goes to CH.
  - Otherwise, when `timer == WL_CYCLES-1`, go to WLCM.
  - On leaving WL, `W_or_L <= 00`. `score` is held until the next CH→GAME.
- `score` saturates at 127. This is unreachable while `WIN_TICKS` ≤ 127.

## Timing
- Reset values: `presente = OFF`, `W_or_L = 00`, `personaje = 0`, `score = 0`, `timer = 0`, all `btn_*_q = 0`.
- All outputs are registered and change only on `posedge clk` or asynchronously on `rst`.
- Latency: an input sampled high at clk edge k updates outputs at edge k.
  - This covers a button rising edge, `tick_obs`, and `tick_obs && colision`.
  - The results are visible after edge k, with no extra pipeline stage.
- WLCM entered at edge k leaves at edge k+`WLCM_CYCLES`. WL uses the same rule with `WL_CYCLES`.
- `rst` mid-game: outputs return to reset values immediately. After release, the machine waits in OFF for `btn_power_e`. A button already high at release produces no edge until it is released and pressed again.

## Test plan
- Reset/power-on:
  - Assert `rst` with all buttons high → `presente = 0`, `W_or_L = 00`, `score = 0`.
  - Release, then hold `btn_power` → remains OFF.
  - Release and press `btn_power` → `presente = 1` the same cycle.
- Welcome timeout and select (`WLCM_CYCLES = 10`):
  - Enter WLCM → `presente = 2` exactly 10 cycles later.
  - Five `btn_sel` pulses → `personaje = 1`.
  - Same-cycle sel+start → `presente = 3`, `personaje` unchanged.
- Win (`WIN_TICKS = 5`): five `tick_obs` pulses with `colision = 0` → `score = 5`, `W_or_L = 10`, `presente = 4` on the fifth tick edge.
- Loss:
  - Two clean ticks, then `colision = 1` without tick → no change.
  - Next tick with collision → `W_or_L = 01`, `score = 2`, `presente = 4`.
- Pause:
  - `btn_pause` and `tick_obs` in the same cycle → `presente = 5`, `score` unchanged.
  - Ticks and collisions during PA → ignored.
  - `btn_pause` again → `presente = 3`.
- WL exit and power override (`WL_CYCLES = 8`):
  - From WL → `presente = 1`, `W_or_L = 00` after 8 cycles.
  - `btn_power` in GAME during a tick → `presente = 0`, `score = 0`.

Source files
------------

// File: rtl/control_juego_if.sv
// control_juego_if: player buttons, obstacle events and game status between HEROE blocks
interface control_juego_if;
    logic       btn_power;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_sel;
    logic       tick_obs;
    logic       colision;
    logic [2:0] presente;
    logic [1:0] W_or_L;
    logic [1:0] personaje;
    logic [6:0] score;
    modport master (
        output btn_power, btn_start, btn_pause, btn_sel, tick_obs, colision,
        input  presente, W_or_L, personaje, score
    );
    modport slave (
        input  btn_power, btn_start, btn_pause, btn_sel, tick_obs, colision,
        output presente, W_or_L, personaje, score
    );
endinterface

// File: rtl/control_juego.sv
// control_juego: HEROE game sequencer driving state, win/lose flag, character and score
module control_juego #(
    parameter int unsigned WLCM_CYCLES = 27_000_000,
    parameter int unsigned WL_CYCLES   = 81_000_000,
    parameter logic [6:0]  WIN_TICKS   = 7'd60,
    parameter logic [2:0]  OFF         = 3'd0,
    parameter logic [2:0]  WLCM        = 3'd1,
    parameter logic [2:0]  CH          = 3'd2,
    parameter logic [2:0]  GAME        = 3'd3,
    parameter logic [2:0]  WL          = 3'd4,
    parameter logic [2:0]  PA          = 3'd5
) (
    input  logic           clk,
    input  logic           rst,
    control_juego_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF = OFF, S_WLCM = WLCM, S_CH = CH, S_GAME = GAME, S_WL = WL, S_PA = PA
    } state_t;

    state_t      r_state, w_state_n;
    logic [1:0]  r_wl, w_wl_n;
    logic [1:0]  r_pers, w_pers_n;
    logic [6:0]  r_score, w_score_n;
    logic [26:0] r_timer, w_timer_n;
    logic [3:0]  r_btn_q;
    logic        r_arm;
    logic [3:0]  w_btn, w_edge;
    logic [7:0]  w_inc;
    logic        w_pwr_e, w_start_e, w_pause_e, w_sel_e;
    logic        w_wlcm_done, w_wl_done;

    // r_arm masks the first clock after reset so a button held through reset never fires
    assign w_btn       = {bus.btn_power, bus.btn_start, bus.btn_pause, bus.btn_sel};
    assign w_edge      = w_btn & ~r_btn_q & {4{r_arm}};
    assign w_pwr_e     = w_edge[3];
    assign w_start_e   = w_edge[2];
    assign w_pause_e   = w_edge[1];
    assign w_sel_e     = w_edge[0];
    assign w_inc       = {1'b0, r_score} + 8'd1;
    assign w_wlcm_done = r_timer == 27'(WLCM_CYCLES - 1);
    assign w_wl_done   = r_timer == 27'(WL_CYCLES - 1);

    // next state and next values of every game register; power edge overrides all
    always_comb begin
        w_state_n = r_state;
        w_wl_n    = r_wl;
        w_pers_n  = r_pers;
        w_score_n = r_score;
        if (r_state != S_OFF && w_pwr_e) begin
            w_state_n = S_OFF;
            w_wl_n    = 2'b00;
            w_score_n = 7'd0;
        end else begin
            case (r_state)
                S_OFF:  w_state_n = w_pwr_e ? S_WLCM : S_OFF;
                S_WLCM: w_state_n = (w_start_e || w_wlcm_done) ? S_CH : S_WLCM;
                S_CH: begin
                    if (w_start_e) begin
                        w_state_n = S_GAME;
                        w_score_n = 7'd0;
                        w_wl_n    = 2'b00;
                    end else if (w_sel_e) begin
                        w_pers_n = r_pers + 2'd1;
                    end
                end
                S_GAME: begin
                    if (w_pause_e) begin
                        w_state_n = S_PA;
                    end else if (bus.tick_obs && bus.colision) begin
                        w_wl_n    = 2'b01;
                        w_state_n = S_WL;
                    end else if (bus.tick_obs) begin
                        w_score_n = (r_score == 7'd127) ? r_score : w_inc[6:0];
                        if (w_inc == {1'b0, WIN_TICKS}) begin
                            w_wl_n    = 2'b10;
                            w_state_n = S_WL;
                        end
                    end
                end
                S_PA:   w_state_n = w_pause_e ? S_GAME : S_PA;
                S_WL: begin
                    if (w_start_e || w_wl_done) begin
                        w_state_n = w_start_e ? S_CH : S_WLCM;
                        w_wl_n    = 2'b00;
                    end
                end
                default: w_state_n = S_OFF;
            endcase
        end
        w_timer_n = (w_state_n != r_state) ? 27'd0 :
                    (r_state == S_WLCM || r_state == S_WL) ? r_timer + 27'd1 : r_timer;
    end

    // state and outputs registers, plus button history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
            r_wl    <= 2'b00;
            r_pers  <= 2'd0;
            r_score <= 7'd0;
            r_timer <= 27'd0;
            r_btn_q <= 4'd0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_wl    <= w_wl_n;
            r_pers  <= w_pers_n;
            r_score <= w_score_n;
            r_timer <= w_timer_n;
            r_btn_q <= w_btn;
            r_arm   <= 1'b1;
        end
    end

    assign bus.presente  = r_state;
    assign bus.W_or_L    = r_wl;
    assign bus.personaje = r_pers;
    assign bus.score     = r_score;
endmodule

// File: tb/tb_control_juego.sv
// tb_control_juego: directed plus random stimulus against a behavioural game model
module tb_control_juego;
    localparam int WLCM_N = 10;
    localparam int WL_N   = 8;
    localparam int WIN_N  = 5;
    localparam logic [3:0] P  = 4'b1000;
    localparam logic [3:0] S  = 4'b0100;
    localparam logic [3:0] PZ = 4'b0010;
    localparam logic [3:0] SE = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    control_juego_if bus();
    control_juego #(
        .WLCM_CYCLES(WLCM_N), .WL_CYCLES(WL_N), .WIN_TICKS(7'd5)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int m_st = 0, m_wl = 0, m_pers = 0, m_score = 0, m_enter = 0, cyc = 0;
    logic [3:0] btn = 4'd0;
    logic [3:0] prev = 4'd0;
    logic [3:0] nb;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic check_all();
        chk("presente", int'(bus.presente), m_st);
        chk("W_or_L", int'(bus.W_or_L), m_wl);
        chk("personaje", int'(bus.personaje), m_pers);
        chk("score", int'(bus.score), m_score);
    endtask

    task automatic drive(input logic [3:0] b, input logic tk, input logic co);
        btn = b;
        bus.btn_power = b[3];
        bus.btn_start = b[2];
        bus.btn_pause = b[1];
        bus.btn_sel   = b[0];
        bus.tick_obs  = tk;
        bus.colision  = co;
    endtask

    // game rules applied once per clock edge; screen timeouts kept as entry-cycle deadlines
    task automatic model(input logic tk, input logic co);
        logic [3:0] e;
        int ns;
        e = btn & ~prev;
        ns = m_st;
        cyc++;
        if (m_st != 0 && e[3]) begin
            ns = 0; m_wl = 0; m_score = 0;
        end else begin
            case (m_st)
                0: if (e[3]) ns = 1;
                1: if (e[2] || cyc == m_enter + WLCM_N) ns = 2;
                2: if (e[2]) begin ns = 3; m_score = 0; m_wl = 0; end
                   else if (e[0]) m_pers = (m_pers + 1) % 4;
                3: if (e[1]) ns = 5;
                   else if (tk && co) begin m_wl = 1; ns = 4; end
                   else if (tk) begin
                       m_score = (m_score < 127) ? m_score + 1 : 127;
                       if (m_score == WIN_N) begin m_wl = 2; ns = 4; end
                   end
                5: if (e[1]) ns = 3;
                4: if (e[2]) begin ns = 2; m_wl = 0; end
                   else if (cyc == m_enter + WL_N) begin ns = 1; m_wl = 0; end
                default: ;
            endcase
        end
        if (ns != m_st) m_enter = cyc;
        m_st = ns;
        prev = btn;
    endtask

    task automatic step(input logic [3:0] b, input logic tk, input logic co);
        @(negedge clk);
        drive(b, tk, co);
        @(posedge clk);
        model(tk, co);
        #1 check_all();
    endtask

    task automatic do_reset(input logic [3:0] b);
        @(negedge clk);
        drive(b, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_presente", int'(bus.presente), 0);
        chk("rst_W_or_L", int'(bus.W_or_L), 0);
        chk("rst_score", int'(bus.score), 0);
        chk("rst_personaje", int'(bus.personaje), 0);
        m_st = 0; m_wl = 0; m_pers = 0; m_score = 0;
        @(negedge clk);
        rst = 1'b0;
        prev = b;
        @(posedge clk);
        model(1'b0, 1'b0);
        #1 check_all();
    endtask

    initial begin
        drive(4'd0, 1'b0, 1'b0);
        do_reset(4'b1111);
        repeat (3) step(P, 0, 0);
        chk("held_power_off", int'(bus.presente), 0);
        step(0, 0, 0);
        step(P, 0, 0);
        chk("power_on", int'(bus.presente), 1);
        repeat (WLCM_N - 1) step(0, 0, 0);
        chk("wlcm_hold", int'(bus.presente), 1);
        step(0, 0, 0);
        chk("wlcm_timeout", int'(bus.presente), 2);
        repeat (5) begin step(SE, 0, 0); step(0, 0, 0); end
        chk("sel5", int'(bus.personaje), 1);
        step(S | SE, 0, 0);
        chk("start_wins_state", int'(bus.presente), 3);
        chk("start_wins_pers", int'(bus.personaje), 1);
        for (int i = 0; i < WIN_N; i++) begin step(0, 0, 0); step(0, 1, 0); end
        chk("win_score", int'(bus.score), 5);
        chk("win_flag", int'(bus.W_or_L), 2);
        chk("win_state", int'(bus.presente), 4);
        repeat (WL_N - 1) step(0, 0, 0);
        chk("wl_hold", int'(bus.presente), 4);
        step(0, 0, 0);
        chk("wl_timeout", int'(bus.presente), 1);
        chk("wl_exit_flag", int'(bus.W_or_L), 0);
        chk("score_held", int'(bus.score), 5);
        step(S, 0, 0);
        step(0, 0, 0);
        step(S, 0, 0);
        chk("game_score_clr", int'(bus.score), 0);
        step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
        step(0, 0, 1);
        chk("col_no_tick_state", int'(bus.presente), 3);
        chk("col_no_tick_score", int'(bus.score), 2);
        step(0, 1, 1);
        chk("loss_flag", int'(bus.W_or_L), 1);
        chk("loss_score", int'(bus.score), 2);
        chk("loss_state", int'(bus.presente), 4);
        step(S, 0, 0); step(0, 0, 0); step(S, 0, 0); step(0, 0, 0);
        step(0, 1, 0);
        step(PZ, 1, 0);
        chk("pause_state", int'(bus.presente), 5);
        chk("pause_score", int'(bus.score), 1);
        step(0, 1, 1); step(0, 1, 0);
        chk("pa_ignores", int'(bus.score), 1);
        step(PZ, 0, 0);
        chk("resume", int'(bus.presente), 3);
        step(0, 0, 0);
        step(P, 1, 0);
        chk("power_override_state", int'(bus.presente), 0);
        chk("power_override_score", int'(bus.score), 0);
        step(0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(4'($urandom));
            end else begin
                nb = btn;
                if ($urandom_range(0, 59) == 0) nb[3] = ~nb[3];
                if ($urandom_range(0, 5) == 0) nb[2] = ~nb[2];
                if ($urandom_range(0, 9) == 0) nb[1] = ~nb[1];
                if ($urandom_range(0, 4) == 0) nb[0] = ~nb[0];
                step(nb, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
